// File: rtl/float_to_int_if.sv
// Operand and result handshakes of the float-to-integer stage.
// The operand side faces the FPU adder and the result side faces the next consumer.
interface float_to_int_if;
   logic [31:0] input_a;
   logic        input_a_valid;
   logic        input_a_ack;
   logic [31:0] output_z;
   logic        output_z_valid;
   logic        output_z_ack;

   // Producer of operands and consumer of results.
   modport master (
      output input_a,
      output input_a_valid,
      input  input_a_ack,
      input  output_z,
      input  output_z_valid,
      output output_z_ack
   );

   // The conversion block itself.
   modport slave (
      input  input_a,
      input  input_a_valid,
      output input_a_ack,
      output output_z,
      output output_z_valid,
      input  output_z_ack
   );
endinterface

// File: rtl/float_to_int.sv
// IEEE-754 single precision to 32-bit signed integer, truncating toward zero.
// The mantissa is aligned with a one-bit-per-cycle shifter, so a conversion
// takes between a few and a few dozen cycles. Only one operand is ever in flight.
module float_to_int #(
   parameter logic [31:0] OVERFLOW_VALUE = 32'h80000000
) (
   input  logic          clk,
   input  logic          rst,          // asynchronous, active low
   float_to_int_if.slave bus,
   output logic          idle_status
);

   typedef enum logic [2:0] {
      WAIT_IN,
      UNPACK,
      SPECIAL,
      CONVERT,
      SIGN,
      PUT
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        m_q, m_d;
   logic [31:0]        z_q, z_d;
   logic signed [9:0]  e_q, e_d;
   logic               s_q, s_d;
   logic               ack_q, ack_d;
   logic               valid_q, valid_d;

   // Next-state and datapath decisions for every state of the converter.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      m_d     = m_q;
      z_d     = z_q;
      e_d     = e_q;
      s_d     = s_q;
      ack_d   = ack_q;
      valid_d = valid_q;

      case (state_q)
         WAIT_IN: begin
            // Offer ack one cycle after arriving here, then hold it until a transfer.
            if (!ack_q) begin
               ack_d = 1'b1;
            end else if (bus.input_a_valid) begin
               a_d     = bus.input_a;
               ack_d   = 1'b0;
               state_d = UNPACK;
            end
         end

         UNPACK: begin
            s_d     = a_q[31];
            e_d     = $signed({2'b00, a_q[30:23]}) - 10'sd127;
            // Hidden one sits in bit 31 with weight 2^e.
            m_d     = {1'b1, a_q[22:0], 8'b0};
            state_d = SPECIAL;
         end

         SPECIAL: begin
            // NaN, infinities and anything with |x| >= 2^31 saturate to one code;
            // -2^31 lands here as well and that code is its exact value.
            if (a_q[30:23] == 8'hFF || e_q >= 10'sd31) begin
               z_d     = OVERFLOW_VALUE;
               state_d = PUT;
            end else if (e_q < 10'sd0) begin
               // |x| < 1 covers zeros and denormals; both signs truncate to 0.
               z_d     = 32'd0;
               state_d = PUT;
            end else begin
               state_d = CONVERT;
            end
         end

         CONVERT: begin
            // Shift until the hidden one reaches weight 2^0 at e == 31; the
            // edge that lifts e to 31 also moves on, so no idle cycle is spent.
            m_d = m_q >> 1;
            e_d = e_q + 10'sd1;
            if (e_q == 10'sd30) begin
               state_d = SIGN;
            end
         end

         SIGN: begin
            // Magnitude is below 2^31 here, so negation cannot overflow.
            z_d     = s_q ? (~m_q + 32'd1) : m_q;
            state_d = PUT;
         end

         PUT: begin
            // Raise valid one cycle after arriving; an ack seen before that is ignored.
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (bus.output_z_ack) begin
               valid_d = 1'b0;
               state_d = WAIT_IN;
            end
         end

         default: begin
            state_d = WAIT_IN;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WAIT_IN;
         a_q     <= 32'd0;
         m_q     <= 32'd0;
         z_q     <= 32'd0;
         e_q     <= 10'sd0;
         s_q     <= 1'b0;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         z_q     <= z_d;
         e_q     <= e_d;
         s_q     <= s_d;
         ack_q   <= ack_d;
         valid_q <= valid_d;
      end
   end

   assign bus.input_a_ack    = ack_q;
   assign bus.output_z       = z_q;
   assign bus.output_z_valid = valid_q;
   assign idle_status        = (state_q == WAIT_IN);

endmodule
